ddr4_cmd_scheduler: RTL and testbench

DDR4_CMD_SCHEDULER -- requirements
Module: ddr4_cmd_scheduler

---
 rtl/ddr4_cmd_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr4_cmd_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_scheduler.sv
// Single-rank DDR4 command scheduler: one request at a time, open-row tracking per bank,
// CAS-latency data pipeline for overlapping accesses, and periodic refresh.
module ddr4_cmd_scheduler #(
    parameter int CAS_LATENCY        = 22,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int REFRESH_LATENCY    = 16,
    parameter int REFRESH_CYCLE      = 5120,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_N_in,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic                         req_write_in,
    input  logic [ROW_BITS+4+COL_BITS-1:0] req_addr_in,
    input  logic [63:0]                  req_wdata_in,
    output logic                         resp_valid_out,
    output logic [63:0]                  resp_rdata_out,
    output logic                         cs_N_out,
    output logic                         cke_out,
    output logic                         act_N_out,
    output logic [16:0]                  addr_out,
    output logic [1:0]                   bg_out,
    output logic [1:0]                   ba_out,
    output logic [63:0]                  dqm_out,
    output logic [63:0]                  dq_out,
    output logic                         dq_oe_out,
    input  logic [63:0]                  dq_in,
    output logic [3:0]                   state_dbg_out
);
    localparam int AW   = ROW_BITS + 4 + COL_BITS;
    localparam int RC_W = ($clog2(REFRESH_CYCLE) > 13) ? $clog2(REFRESH_CYCLE) : 13;

    typedef enum logic [3:0] {
        IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS,
        REF_PRE, REF_WAIT_RP, REF, REF_WAIT_RFC
    } state_t;

    state_t                state, state_next;
    logic [15:0]           cnt, cnt_next;
    logic                  accept, ref_done, pipe_busy;
    logic [15:0]           open_flag;
    logic [ROW_BITS-1:0]   open_row [16];
    logic [RC_W-1:0]       ref_cnt;
    logic                  ref_pending;
    logic                  req_write_q;
    logic [ROW_BITS-1:0]   req_row_q;
    logic [3:0]            req_bank_q;
    logic [COL_BITS-1:0]   req_col_q;
    logic [63:0]           req_wdata_q;
    logic [CAS_LATENCY-1:0] pipe_valid, pipe_write;
    logic [63:0]           pipe_wdata [CAS_LATENCY-1];
    logic                  cke_q;

    logic [ROW_BITS-1:0]   in_row;
    logic [3:0]            in_bank;
    logic [COL_BITS-1:0]   in_col;

    assign in_row        = req_addr_in[AW-1 -: ROW_BITS];
    assign in_bank       = req_addr_in[COL_BITS+3:COL_BITS];
    assign in_col        = req_addr_in[COL_BITS-1:0];
    assign pipe_busy     = |pipe_valid;
    assign dqm_out       = '0;
    assign cke_out       = cke_q;
    assign state_dbg_out = state;

    // Request handshake: a request transfers on a clock edge where req_valid_in and
    // req_ready_out are both high; ready depends only on state and refresh_pending.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        accept        = 1'b0;
        ref_done      = 1'b0;
        req_ready_out = 1'b0;
        cs_N_out      = 1'b1;
        act_N_out     = 1'b1;
        addr_out      = '0;
        bg_out        = '0;
        ba_out        = '0;
        case (state)
            IDLE: begin
                req_ready_out = !ref_pending;
                if (ref_pending) begin
                    state_next = REF_PRE;
                end else if (req_valid_in) begin
                    accept = 1'b1;
                    if (!open_flag[in_bank])                 state_next = ACT;
                    else if (open_row[in_bank] == in_row)    state_next = CAS;
                    else                                     state_next = PRE;
                end
            end
            PRE: begin
                cs_N_out   = 1'b0;
                addr_out   = {3'b010, 14'd0};
                {bg_out, ba_out} = req_bank_q;
                cnt_next   = 16'(PRECHARGE_LATENCY - 2);
                state_next = WAIT_RP;
            end
            WAIT_RP: begin
                if (cnt == 16'd0) state_next = ACT;
                else              cnt_next = cnt - 16'd1;
            end
            ACT: begin
                cs_N_out   = 1'b0;
                act_N_out  = 1'b0;
                addr_out   = 17'(req_row_q);
                {bg_out, ba_out} = req_bank_q;
                cnt_next   = 16'(ACTIVATION_LATENCY - 2);
                state_next = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (cnt == 16'd0) state_next = CAS;
                else              cnt_next = cnt - 16'd1;
            end
            CAS: begin
                cs_N_out   = 1'b0;
                addr_out   = {(req_write_q ? 3'b100 : 3'b101), 14'(req_col_q)};
                {bg_out, ba_out} = req_bank_q;
                state_next = IDLE;
            end
            REF_PRE: begin
                // REF must not overlap data beats still in the pipeline
                if (!pipe_busy) begin
                    cs_N_out   = 1'b0;
                    addr_out   = {3'b010, 3'b000, 1'b1, 10'd0};
                    cnt_next   = 16'(PRECHARGE_LATENCY - 2);
                    state_next = REF_WAIT_RP;
                end
            end
            REF_WAIT_RP: begin
                if (cnt == 16'd0) state_next = REF;
                else              cnt_next = cnt - 16'd1;
            end
            REF: begin
                cs_N_out   = 1'b0;
                addr_out   = {3'b001, 14'd0};
                cnt_next   = 16'(REFRESH_LATENCY - 1);
                state_next = REF_WAIT_RFC;
            end
            REF_WAIT_RFC: begin
                if (cnt == 16'd0) begin
                    ref_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state <= IDLE;
            cnt   <= '0;
            cke_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cke_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            req_write_q <= 1'b0;
            req_row_q   <= '0;
            req_bank_q  <= '0;
            req_col_q   <= '0;
            req_wdata_q <= '0;
            open_flag   <= '0;
            for (int i = 0; i < 16; i++) open_row[i] <= '0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (accept) begin
                req_write_q <= req_write_in;
                req_row_q   <= in_row;
                req_bank_q  <= in_bank;
                req_col_q   <= in_col;
                req_wdata_q <= req_wdata_in;
            end
            if (ref_done) begin
                open_flag <= '0;
            end else if (state == ACT) begin
                open_flag[req_bank_q] <= 1'b1;
                open_row[req_bank_q]  <= req_row_q;
            end else if (state == PRE) begin
                open_flag[req_bank_q] <= 1'b0;
            end
            // A wrap while already pending just keeps the single flag set
            if (ref_cnt == RC_W'(REFRESH_CYCLE - 1)) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
                if (ref_done) ref_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            pipe_valid     <= '0;
            pipe_write     <= '0;
            for (int i = 0; i < CAS_LATENCY - 1; i++) pipe_wdata[i] <= '0;
            dq_oe_out      <= 1'b0;
            dq_out         <= '0;
            resp_valid_out <= 1'b0;
            resp_rdata_out <= '0;
        end else begin
            pipe_valid    <= {pipe_valid[CAS_LATENCY-2:0], (state == CAS)};
            pipe_write    <= {pipe_write[CAS_LATENCY-2:0], req_write_q};
            pipe_wdata[0] <= req_wdata_q;
            for (int i = 1; i < CAS_LATENCY - 1; i++) pipe_wdata[i] <= pipe_wdata[i-1];
            // Stage CL-2 registers into the output so the beat lands exactly at C+CL
            dq_oe_out <= pipe_valid[CAS_LATENCY-2] & pipe_write[CAS_LATENCY-2];
            dq_out    <= (pipe_valid[CAS_LATENCY-2] & pipe_write[CAS_LATENCY-2]) ?
                         pipe_wdata[CAS_LATENCY-2] : 64'd0;
            resp_valid_out <= pipe_valid[CAS_LATENCY-1] & ~pipe_write[CAS_LATENCY-1];
            if (pipe_valid[CAS_LATENCY-1] & ~pipe_write[CAS_LATENCY-1])
                resp_rdata_out <= dq_in;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed bench for ddr4_cmd_scheduler: expected commands, write beats and read responses
// are queued at issue time and checked by a negedge monitor against the DUT outputs.
`timescale 1ns/1ps
module tb_ddr4_cmd_scheduler;
    localparam int CMD_W = 54;
    localparam int EV_W  = 96;

    logic        clk_in = 1'b0;
    logic        rst_N_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_write_in = 1'b0;
    logic [15:0] req_addr_in = '0;
    logic [63:0] req_wdata_in = '0;
    logic        resp_valid_out;
    logic [63:0] resp_rdata_out;
    logic        cs_N_out, cke_out, act_N_out;
    logic [16:0] addr_out;
    logic [1:0]  bg_out, ba_out;
    logic [63:0] dqm_out, dq_out;
    logic        dq_oe_out;
    logic [63:0] dq_in = '0;
    logic [3:0]  state_dbg_out;

    ddr4_cmd_scheduler dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
        .cs_N_out(cs_N_out), .cke_out(cke_out), .act_N_out(act_N_out),
        .addr_out(addr_out), .bg_out(bg_out), .ba_out(ba_out),
        .dqm_out(dqm_out), .dq_out(dq_out), .dq_oe_out(dq_oe_out), .dq_in(dq_in),
        .state_dbg_out(state_dbg_out)
    );

    // Clock / reset-relative cycle counter (equals the DUT refresh counter value)
    always #5 clk_in = ~clk_in;
    int cyc;
    always @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    function automatic logic [63:0] pat(input int c);
        return {32'hBEEF_0000 + 32'(c), 32'h5A5A_0000 ^ 32'(c)};
    endfunction

    always @(negedge clk_in) dq_in = pat(cyc);

    // Scoreboard
    logic [CMD_W-1:0] exp_cmd_q[$];
    logic [EV_W-1:0]  exp_wr_q[$];
    logic [EV_W-1:0]  exp_rd_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] got);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h at cycle %0d, required no event", name, got, cyc);
    endtask

    function automatic logic [CMD_W-1:0] cmd_ev(input int c, input logic act_n,
                                                  input logic [16:0] a, input logic [1:0] bg,
                                                  input logic [1:0] ba);
        return {32'(c), act_n, a, bg, ba};
    endfunction

    task automatic exp_act(input int c, input logic [7:0] row, input logic [1:0] bg, input logic [1:0] ba);
        exp_cmd_q.push_back(cmd_ev(c, 1'b0, 17'(row), bg, ba));
    endtask

    task automatic exp_cmd(input int c, input logic [2:0] op, input logic [13:0] low,
                           input logic [1:0] bg, input logic [1:0] ba);
        exp_cmd_q.push_back(cmd_ev(c, 1'b1, {op, low}, bg, ba));
    endtask

    // Monitor
    always @(negedge clk_in) begin
        logic [CMD_W-1:0] e;
        logic [EV_W-1:0]  ev;
        if (rst_N_in) begin
            if (!cs_N_out) begin
                check("dqm", 128'(dqm_out), 128'(0));
                if (exp_cmd_q.size() == 0) unexpected("unexpected_cmd", 128'({act_N_out, addr_out, bg_out, ba_out}));
                else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd", 128'(cmd_ev(cyc, act_N_out, addr_out, bg_out, ba_out)), 128'(e));
                end
            end
            if (dq_oe_out) begin
                if (exp_wr_q.size() == 0) unexpected("unexpected_wr_beat", 128'(dq_out));
                else begin
                    ev = exp_wr_q.pop_front();
                    check("wr_beat", 128'({32'(cyc), dq_out}), 128'(ev));
                end
            end
            if (resp_valid_out) begin
                if (exp_rd_q.size() == 0) unexpected("unexpected_resp", 128'(resp_rdata_out));
                else begin
                    ev = exp_rd_q.pop_front();
                    check("rd_resp", 128'({32'(cyc), resp_rdata_out}), 128'(ev));
                end
            end
        end
    end

    // Driver
    task automatic send(input logic wr, input logic [15:0] addr, input logic [63:0] wd, output int t);
        int waited;
        @(negedge clk_in);
        req_valid_in = 1'b1;
        req_write_in = wr;
        req_addr_in  = addr;
        req_wdata_in = wd;
        waited = 0;
        while (!req_ready_out && waited < 100) begin
            @(negedge clk_in);
            waited++;
        end
        t = cyc;
        if (!req_ready_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: ready low for %0d cycles, required acceptance", waited);
            t = -1000;
        end
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_cmd_q.size() + exp_wr_q.size() + exp_rd_q.size()) != 0 && i < 200) begin
            @(negedge clk_in);
            i++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},    128'(cs_N_out), 128'(1));
        check({tag, "_act"},   128'(act_N_out), 128'(1));
        check({tag, "_addr"},  128'(addr_out), 128'(0));
        check({tag, "_bgba"},  128'({bg_out, ba_out}), 128'(0));
        check({tag, "_cke"},   128'(cke_out), 128'(0));
        check({tag, "_dq"},    128'({dq_oe_out, dq_out}), 128'(0));
        check({tag, "_resp"},  128'({resp_valid_out, resp_rdata_out}), 128'(0));
        check({tag, "_state"}, 128'(state_dbg_out), 128'(0));
    endtask

    initial begin
        int t, t2;
        int left;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk_in);
        rst_N_in = 1'b1;
        #1 check("cke_before_edge", 128'(cke_out), 128'(0));
        @(negedge clk_in);
        check("cke_after_reset", 128'(cke_out), 128'(1));

        // Cold read row 0x12 bg1 ba2 col3
        send(1'b0, {8'h12, 2'd1, 2'd2, 4'd3}, 64'd0, t);
        exp_act(t + 1, 8'h12, 2'd1, 2'd2);
        exp_cmd(t + 9, 3'b101, 14'd3, 2'd1, 2'd2);
        exp_rd_q.push_back({32'(t + 32), pat(t + 31)});

        // Row-hit write
        send(1'b1, {8'h12, 2'd1, 2'd2, 4'd5}, 64'hDEADBEEF_CAFEF00D, t);
        exp_cmd(t + 1, 3'b100, 14'd5, 2'd1, 2'd2);
        exp_wr_q.push_back({32'(t + 23), 64'hDEADBEEF_CAFEF00D});

        // Row conflict, row 0x34
        send(1'b0, {8'h34, 2'd1, 2'd2, 4'd7}, 64'd0, t);
        exp_cmd(t + 1, 3'b010, 14'd0, 2'd1, 2'd2);
        exp_act(t + 6, 8'h34, 2'd1, 2'd2);
        exp_cmd(t + 14, 3'b101, 14'd7, 2'd1, 2'd2);
        exp_rd_q.push_back({32'(t + 37), pat(t + 36)});

        // Back-to-back row-hit reads on the new open row
        send(1'b0, {8'h34, 2'd1, 2'd2, 4'd1}, 64'd0, t);
        exp_cmd(t + 1, 3'b101, 14'd1, 2'd1, 2'd2);
        exp_rd_q.push_back({32'(t + 24), pat(t + 23)});
        send(1'b0, {8'h34, 2'd1, 2'd2, 4'd2}, 64'd0, t2);
        exp_cmd(t2 + 1, 3'b101, 14'd2, 2'd1, 2'd2);
        exp_rd_q.push_back({32'(t2 + 24), pat(t2 + 23)});
        check("rd_spacing", 128'(t2 - t), 128'(2));

        // Write to a closed bank in another bank group
        send(1'b1, {8'h5C, 2'd2, 2'd3, 4'h9}, 64'h01234567_89ABCDEF, t);
        exp_act(t + 1, 8'h5C, 2'd2, 2'd3);
        exp_cmd(t + 9, 3'b100, 14'd9, 2'd2, 2'd3);
        exp_wr_q.push_back({32'(t + 31), 64'h01234567_89ABCDEF});
        drain();

        // Refresh: counter wraps after cycle 5119, request held from cycle 5120
        for (int i = 0; i < 6000 && cyc != 5119; i++) @(negedge clk_in);
        check("reach_refresh_cycle", 128'(cyc), 128'(5119));
        exp_cmd(5121, 3'b010, 14'h0400, 2'd0, 2'd0);
        exp_cmd(5126, 3'b001, 14'd0, 2'd0, 2'd0);
        send(1'b0, {8'h34, 2'd1, 2'd2, 4'd6}, 64'd0, t);
        check("refresh_accept_cycle", 128'(t), 128'(5143));
        exp_act(t + 1, 8'h34, 2'd1, 2'd2);
        exp_cmd(t + 9, 3'b101, 14'd6, 2'd1, 2'd2);
        exp_rd_q.push_back({32'(t + 32), pat(t + 31)});
        drain();

        // Reset 10 cycles after a RD: in-flight read must vanish
        send(1'b0, {8'h77, 2'd2, 2'd1, 4'd4}, 64'd0, t);
        exp_act(t + 1, 8'h77, 2'd2, 2'd1);
        exp_cmd(t + 9, 3'b101, 14'd4, 2'd2, 2'd1);
        for (int i = 0; i < 100 && cyc != t + 19; i++) @(negedge clk_in);
        #2 rst_N_in = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clk_in);
        rst_N_in = 1'b1;
        repeat (40) @(negedge clk_in);

        // Open flags were cleared by reset: same row needs ACT again
        send(1'b0, {8'h77, 2'd2, 2'd1, 4'd4}, 64'd0, t);
        exp_act(t + 1, 8'h77, 2'd2, 2'd1);
        exp_cmd(t + 9, 3'b101, 14'd4, 2'd2, 2'd1);
        exp_rd_q.push_back({32'(t + 32), pat(t + 31)});
        drain();
        repeat (5) @(negedge clk_in);

        left = exp_cmd_q.size() + exp_wr_q.size() + exp_rd_q.size();
        check("scoreboard_empty", 128'(left), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
